// File: rtl/acq_stream_pkg.sv
// Shared types and constants for the acquisition stream multiplexer.
package acq_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StStream,
    StTrailerCnt,
    StTrailerTag
  } acq_state_e;

  localparam logic [15:0] DefaultHeaderTag  = 16'hA5A5;
  localparam logic [15:0] DefaultTrailerTag = 16'h5A5A;

  // Width of a source index; never below one bit.
  function automatic int unsigned sel_w(input int unsigned n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/acq_sync_fifo.sv
// Small synchronous FIFO with occupancy count; read data is the word at the head.
module acq_sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/acquisition_stream_mux.sv
// Selects one acquisition source per run, frames it with header/count/trailer words
// and buffers the stream towards the external FIFO.
module acquisition_stream_mux
  import acq_stream_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] HEADER_TAG  = DefaultHeaderTag,
  parameter logic [15:0] TRAILER_TAG = DefaultTrailerTag,
  localparam int unsigned SEL_W      = sel_w(N_SRC)
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        ModeSelect,
  input  logic                    StartStop,
  input  logic [N_SRC*DATA_W-1:0] SrcData,
  input  logic [N_SRC-1:0]        SrcDataEnable,
  output logic [N_SRC-1:0]        SrcFifoFull,
  input  logic                    ExternalFifoFull,
  output logic [DATA_W-1:0]       OutData,
  output logic                    OutDataEnable,
  output logic [SEL_W-1:0]        ActiveMode,
  output logic                    Busy,
  output logic [15:0]             DropCount,
  output logic                    Overflow
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  acq_state_e        state_q, state_d;
  logic              start_prev_q;
  logic [SEL_W-1:0]  active_mode_q;
  logic [DATA_W-1:0] word_cnt_q;
  logic [15:0]       drop_cnt_q;
  logic              overflow_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_en_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  logic              start_rise, src_strobe, almost_full, accept, drop;
  logic [DATA_W-1:0] src_word, header_word;

  assign start_rise  = StartStop & ~start_prev_q;
  assign src_strobe  = SrcDataEnable[active_mode_q];
  assign src_word    = SrcData[active_mode_q*DATA_W +: DATA_W];
  // One slot stays free for source data so backpressure has a cycle of slack.
  assign almost_full = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
  assign header_word = DATA_W'({HEADER_TAG[15:8], 8'(active_mode_q)});
  assign fifo_pop    = ~fifo_empty & ~ExternalFifoFull;

  acq_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencing: next state, FIFO write selection and accept/drop decisions.
  always_comb begin
    state_d    = state_q;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    accept     = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop = src_strobe;
        if (start_rise) state_d = StHeader;
      end
      StHeader: begin
        drop = src_strobe;
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          fifo_wdata = header_word;
          state_d    = StStream;
        end
      end
      StStream: begin
        if (src_strobe) begin
          if (!almost_full) begin
            fifo_push  = 1'b1;
            fifo_wdata = src_word;
            accept     = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
        if (!StartStop) state_d = StTrailerCnt;
      end
      StTrailerCnt: begin
        drop = src_strobe;
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          fifo_wdata = word_cnt_q;
          state_d    = StTrailerTag;
        end
      end
      StTrailerTag: begin
        drop = src_strobe;
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          fifo_wdata = DATA_W'(TRAILER_TAG);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register, run-level history and per-run bookkeeping counters.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      start_prev_q  <= 1'b0;
      active_mode_q <= '0;
      word_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= StartStop;
      if (state_q == StIdle && start_rise) begin
        // A new run starts from clean statistics; this wins over a same-cycle drop.
        active_mode_q <= ModeSelect;
        word_cnt_q    <= '0;
        drop_cnt_q    <= '0;
        overflow_q    <= 1'b0;
      end else begin
        if (accept && word_cnt_q != '1) word_cnt_q <= word_cnt_q + DATA_W'(1);
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
    end
  end

  // Registered output stage fed by the FIFO head.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      out_data_q <= '0;
      out_en_q   <= 1'b0;
    end else begin
      out_en_q <= fifo_pop;
      if (fifo_pop) out_data_q <= fifo_rdata;
    end
  end

  // Backpressure only towards the source currently owning the stream.
  always_comb begin
    SrcFifoFull                = '0;
    SrcFifoFull[active_mode_q] = almost_full | (state_q != StStream);
  end

  assign OutData       = out_data_q;
  assign OutDataEnable = out_en_q;
  assign ActiveMode    = active_mode_q;
  assign Busy          = (state_q != StIdle) | ~fifo_empty;
  assign DropCount     = drop_cnt_q;
  assign Overflow      = overflow_q;

endmodule
